// File: rtl/freq_gen.sv
// freq_gen: programmable 50%-duty square-wave generator.
// A requested frequency in Hz is turned into a half-period in clock cycles
// by an iterative restoring divider (CLK_FREQ / (2*freq), one quotient bit
// per cycle, MSB first), then a counter toggles `sig` every `half` clocks.
module freq_gen #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int FW       = 20,
  parameter int CW       = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [FW-1:0] freq,
  output logic          sig,
  output logic          ready,
  output logic          busy,
  output logic          done_tick,
  output logic [CW-1:0] half
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam int            RW       = CW + 1;
  localparam int            BW       = $clog2(CW + 1);
  localparam logic [CW-1:0] DIVIDEND = CW'(CLK_FREQ);
  localparam logic [BW-1:0] LAST_BIT = BW'(CW - 1);

  logic [1:0]    state;
  logic [FW-1:0] freq_q;
  // The partial remainder never exceeds the dividend prefix already shifted
  // in, which is below 2**CW, so CW bits hold it; only the trial needs CW+1.
  logic [CW-1:0] rem;
  logic [CW-1:0] quo;      // holds unshifted dividend bits, fills with quotient
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] cnt;

  logic [RW-1:0] divisor;
  logic [RW-1:0] trial;
  logic          take;
  logic [CW-1:0] rem_next;
  logic [CW-1:0] quo_next;
  logic [CW-1:0] half_load;
  logic          wrap;

  // One restoring-division step plus the half-period compare.
  always_comb begin
    // NOTE: every always_comb output gets a value up front so no path can
    // leave it unassigned and infer a latch.
    divisor   = RW'({freq_q, 1'b0});
    trial     = {rem, quo[CW-1]};
    take      = (trial >= divisor);
    rem_next  = take ? CW'(trial - divisor) : CW'(trial);
    quo_next  = {quo[CW-2:0], take};
    half_load = (quo_next == '0) ? CW'(1) : quo_next;
    wrap      = (cnt == half - 1'b1);
  end

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_DIV) || (state == S_LOAD);

  // Control FSM, divider datapath and waveform counter.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values and update order inside the block is moot.
    if (rst) begin
      state     <= S_IDLE;
      freq_q    <= '0;
      rem       <= '0;
      quo       <= '0;
      bit_cnt   <= '0;
      cnt       <= '0;
      half      <= '0;
      sig       <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          sig <= 1'b0;
          cnt <= '0;
          if (start && !stop) begin
            if (freq == '0) begin
              done_tick <= 1'b1;
            end else begin
              freq_q  <= freq;
              rem     <= '0;
              quo     <= DIVIDEND;
              bit_cnt <= '0;
              state   <= S_DIV;
            end
          end
        end

        S_DIV: begin
          sig <= 1'b0;
          if (stop) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            rem     <= rem_next;
            quo     <= quo_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              // Final quotient bit lands now, so LOAD already sees `half`.
              half      <= half_load;
              cnt       <= '0;
              done_tick <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end

        default: begin  // S_LOAD and S_RUN share the counting datapath
          if (stop) begin
            sig   <= 1'b0;
            cnt   <= '0;
            state <= S_IDLE;
          end else if (state == S_RUN && start) begin
            sig <= 1'b0;
            cnt <= '0;
            if (freq == '0) begin
              done_tick <= 1'b1;
              state     <= S_IDLE;
            end else begin
              freq_q  <= freq;
              rem     <= '0;
              quo     <= DIVIDEND;
              bit_cnt <= '0;
              state   <= S_DIV;
            end
          end else begin
            state <= S_RUN;
            if (wrap) begin
              cnt <= '0;
              sig <= ~sig;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gen.sv
// Testbench for freq_gen: scoreboard of expected done_tick events (latency
// and half-period) drained by a monitor, plus waveform timing checks.
module tb_freq_gen;

  localparam int CLK_FREQ = 1_000_000;
  localparam int FW       = 20;
  localparam int CW       = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [FW-1:0] freq;
  logic          sig;
  logic          ready;
  logic          busy;
  logic          done_tick;
  logic [CW-1:0] half;

  freq_gen #(.CLK_FREQ(CLK_FREQ), .FW(FW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .freq      (freq),
    .sig       (sig),
    .ready     (ready),
    .busy      (busy),
    .done_tick (done_tick),
    .half      (half)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    longint      half;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     vectors    = 0;
  int     miscompares = 0;
  longint model_half = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: half-period is CLK_FREQ/(2f) truncated, at least 1;
  // a zero request leaves the previous setting in place.
  function automatic longint calc_half(input longint f);
    longint q;
    if (f == 0) return model_half;
    q = CLK_FREQ / (2 * f);
    return (q == 0) ? 1 : q;
  endfunction

  // Monitor: every done_tick must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done_tick) begin
      if (sb.size() == 0) begin
        check("unexpected_done_tick", done_tick, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_latency", cyc, mon_e.due);
        check("done_half", half, mon_e.half);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepted start: push the expected response, then pulse start.
  task automatic issue(input int f);
    exp_t e;
    start = 1'b1;
    freq  = FW'(f);
    e.due = cyc + 1 + ((f == 0) ? 0 : CW);
    model_half = calc_half(f);
    e.half = model_half;
    sb.push_back(e);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int found;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_tick) begin
        found = 1;
        break;
      end
    end
    check("done_seen", found, 1);
  endtask

  // Called at the LOAD-cycle sample: first rise after h clocks, then h high, h low.
  task automatic check_wave(input longint h);
    int n;
    int bound;
    bound = 4 * int'(h) + 8;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig && n < bound);
    check("rise_delay", n, h);
    n = 0;
    while (sig && n < bound) begin
      n++;
      @(negedge clk);
    end
    check("high_time", n, h);
    n = 0;
    while (!sig && n < bound) begin
      n++;
      @(negedge clk);
    end
    check("low_time", n, h);
  endtask

  task automatic do_stop(input bit with_start);
    stop = 1'b1;
    if (with_start) begin
      start = 1'b1;
      freq  = FW'(123);
    end
    step();
    stop  = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("stop_ready", ready, 1);
    check("stop_busy", busy, 0);
    check("stop_sig", sig, 0);
    check("stop_done", done_tick, 0);
    check("stop_half", half, model_half);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nready;
    int nsig;
    rst = 1'b1; start = 1'b0; stop = 1'b0; freq = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sig", sig, 0);
    check("rst_done", done_tick, 0);
    check("rst_half", half, 0);
    rst = 1'b0;
    step();

    // 1: 1 kHz -> half 500
    issue(1000);
    wait_done();
    check_wave(model_half);

    // 2: 3 Hz -> half 166666, busy for CW+1 cycles, ready low throughout
    issue(3);
    n = 0; nready = 0; nsig = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (ready) nready++;
      if (sig) nsig++;
    end
    check("busy_cycles", n, CW + 1);
    check("ready_low", nready, 0);
    check("sig_low_busy", nsig, 0);
    do_stop(0);

    // 3: above CLK_FREQ/2 -> clamp to half 1
    issue(600_000);
    wait_done();
    check_wave(model_half);
    do_stop(0);

    // 4: freq 0 in IDLE -> done_tick next cycle only
    issue(0);
    @(negedge clk);
    check("zero_ready", ready, 1);
    check("zero_busy", busy, 0);
    check("zero_sig", sig, 0);
    @(negedge clk);
    check("zero_done_one_cycle", done_tick, 0);

    // 5: re-tune from RUN, with an ignored start during DIV
    issue(1000);
    wait_done();
    check_wave(model_half);
    issue(250);
    @(negedge clk);
    check("retune_sig", sig, 0);
    check("retune_busy", busy, 1);
    repeat (4) step();
    start = 1'b1; freq = FW'(77);
    step();
    start = 1'b0;
    wait_done();
    check_wave(model_half);

    // 6: stop mid-RUN, stop+start together, reset mid-DIV
    do_stop(0);
    issue(5000);
    wait_done();
    repeat (10) step();
    do_stop(1);
    issue(5000);
    repeat (5) step();
    rst = 1'b1;
    sb.delete();
    model_half = 0;
    step();
    @(negedge clk);
    check("rstdiv_ready", ready, 1);
    check("rstdiv_busy", busy, 0);
    check("rstdiv_sig", sig, 0);
    check("rstdiv_done", done_tick, 0);
    check("rstdiv_half", half, 0);
    rst = 1'b0;
    step();

    // Random frequencies, issued from IDLE or as re-tunes from RUN
    for (int i = 0; i < 8; i++) begin
      issue(int'($urandom_range(700_000, 2000)));
      wait_done();
      check_wave(model_half);
    end

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
- Programmable square-wave generator; the transmit-side counterpart of the auto-scaled frequency counter.
- Takes a requested frequency in Hz and computes the half-period in clock cycles with an iterative restoring divider.
- Drives a 50%-duty square wave on `sig`.
- Used on-board as a stimulus source for the counter and as a standalone test-signal generator.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- FW, 20, width of the requested-frequency input.
- CW, 27, quotient/half-period counter width; must satisfy 2**CW > CLK_FREQ.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; `freq` is sampled on the same edge.
- stop  in  1  stops generation; `sig` returns low.
- freq  in  FW  requested frequency in Hz, unsigned binary.
- sig  out  1  generated square wave.
- ready  out  1  high in IDLE only.
- busy  out  1  high in DIV and LOAD.
- done_tick  out  1  one-cycle pulse when a new setting takes effect.
- half  out  CW  active half-period in clocks; debug and readback.

Behaviour:
- Reset (sync, rst=1):
  - state=IDLE; sig=0, busy=0, done_tick=0, half=0, internal counter=0, ready=1.
  - rst has priority over every other input.
- States and transitions:
  - IDLE: sig=0.
    - start with freq==0: stay in IDLE, done_tick=1 on the next cycle.
    - start with freq!=0: latch freq, go to DIV.
  - DIV: exactly CW cycles.
    - Restoring division: dividend=CLK_FREQ, divisor=2*freq (FW+1 bits), remainder CW+1 bits, one quotient bit per cycle, MSB first.
    - sig held at 0. start ignored.
  - LOAD: one cycle.
    - half = quotient, truncated; if quotient==0, half=1 (clamp for freq > CLK_FREQ/2).
    - Counter=0, sig=0, done_tick=1. Go to RUN.
  - RUN:
    - Counter increments each cycle.
    - When counter==half-1: counter=0 and sig toggles.
    - start with freq!=0 (re-tune): latch freq, go to DIV, sig forced 0.
    - start with freq==0: go to IDLE, done_tick=1 next cycle.
- stop:
  - In DIV, LOAD or RUN: go to IDLE next cycle with sig=0, counter=0, no done_tick.
  - Leaves half at its last value.
  - stop and start in the same cycle: stop wins.
- Timing:
  - start sampled at edge k.
  - DIV occupies cycles k+1..k+CW.
  - LOAD, with done_tick, at cycle k+CW+1.
  - First rising edge of sig at cycle k+CW+1+half.
  - Output period = 2*half clocks exactly; duty 50%; no jitter.
- done_tick asserts for exactly one cycle per accepted start, and never on stop or reset.

Test Plan:
1. CLK_FREQ=1_000_000, CW=20; reset then start with freq=1000 -> done_tick at start+21 cycles, half=500, sig high 500 / low 500 clocks, repeating.
2. freq=3 -> half=166666 (truncated), period 333332 clocks; busy high for 21 cycles, ready low throughout.
3. freq=600_000 -> quotient 0 clamped, half=1, sig toggles every clock.
4. Start in IDLE with freq=0 -> no DIV, done_tick one cycle later, sig stays 0, ready stays 1.
5. In RUN at freq=1000, pulse start with freq=250 -> sig drops to 0 during DIV, half=2000 after done_tick. A start pulse during DIV is ignored (half still 2000).
6. stop asserted mid-RUN, and separately stop+start in the same cycle -> IDLE next cycle, sig=0, no done_tick. rst asserted mid-DIV -> all outputs at reset values next cycle.
